cpu_core: RTL
=============

# cpu_core

Parametrised single-cycle accumulator CPU core: program counter, registers A and B, ALU with status flags, conditional jumps and a halt state. Fetches one instruction per cycle from an external combinational instruction memory and presents ALU and register state on ports for waveform inspection. It is the next-generation replacement for the fixed 8-bit, no-branch computer top level.

## Interface
- DATA_W, 8, datapath width of A, B, K and ALU (4..32)
- ADDR_W, 8, PC / instruction-address width (≤ DATA_W)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  cycle enable; low freezes all state
- im_addr  out  ADDR_W  fetch address (= pc)
- im_data  in  9+DATA_W  instruction word, valid same cycle
- pc  out  ADDR_W  current PC
- reg_a, reg_b  out  DATA_W  register contents
- alu_out  out  DATA_W  combinational ALU result of current instruction
- flags  out  3  {N, Z, C} status register
- halted  out  1  core in HALT state

## Operation
- Instruction: im_data[DATA_W-1:0] = K; opcode = im_data[DATA_W+8:DATA_W].
- Opcode bits: [2:0] alu_sel, [3] ld_a, [4] ld_b, [5] b_src (0 = reg_b, 1 = K), [7:6] jmp, [8] halt.
- alu_sel: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SHL A by 1, 6 SHR A by 1 (logical), 7 NOT A.
- jmp: 00 none, 01 JMP, 10 JZ (taken if Z=1), 11 JNZ (taken if Z=0). Target = K[ADDR_W-1:0].
- Arithmetic modulo 2^DATA_W. C: ADD carry-out; SUB = carry of A+~B+1 (1 when A≥B unsigned); SHL bit shifted out of MSB; SHR bit shifted out of LSB; logic ops C=0. Z = (result==0); N = result MSB.
- ALU instruction (jmp=00, halt=0): load alu_out into A if ld_a, into B if ld_b (both allowed, both get same value); flags always updated (ld_a=ld_b=0 is CMP/TEST); pc ← pc+1.
- Jump instruction (jmp≠00): no register loads, flags unchanged; pc ← target if taken else pc+1.
- halt=1 (any other bits ignored): enter HALT; pc, registers, flags hold.
- States: RUN (after reset), HALT (exit only via rst). en=0 in either state: nothing changes.
- PC wraps 2^ADDR_W−1 → 0 on increment.

## Timing
- Single cycle: decode, ALU, flag and branch evaluation combinational from im_data; all state commits on the rising clk edge.
- im_addr = pc combinationally; memory read latency is zero.
- rst asserted (any time, including mid-cycle): pc=0, reg_a=0, reg_b=0, flags=0, halted=0, state RUN immediately; first instruction executes on first edge after rst deasserts.
- JZ/JNZ test flags as stored before the edge (flags from the previous ALU instruction).
- halted rises the cycle after the halt instruction's edge; im_addr stays at the halt instruction's address.
- alu_out is valid in HALT (reflects current im_data) but causes no update.

## Configuration
- CPU_RETIRE_CNT_EN defined: adds output retired [31:0], reset 0, incremented on each edge with en=1 in RUN (halt instruction counts; HALT cycles do not), wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- cpu_pkg: alu_sel encoding enum, jmp encoding enum, opcode field bit positions, OP_W=9, state enum {RUN, HALT}.
- Sub-module alu_n (parameter DATA_W): inputs a, b, sel; outputs result, n, z, c; purely combinational. Everything else in cpu_core.

## Test plan
- Reset mid-run: load A=0x55, assert rst between edges -> pc, reg_a, reg_b, flags, halted all 0 immediately.
- ADD wrap (DATA_W=8): A=0xF0 via K, ADD K=0x20 to A -> reg_a=0x10, flags {N,Z,C}={0,0,1}.
- CMP then JZ: A=0x07, SUB K=0x07 no loads -> reg_a still 0x07, Z=1, C=1; next JZ K=0x40 -> pc=0x40.
- JNZ not taken with Z=1 at pc=0x12 -> pc=0x13; JMP K=0x00 -> pc=0x00; PC wrap at 0xFF -> 0x00.
- Dual load and source select: B=0x03, ADD from reg_b with ld_a=ld_b=1, A=0x04 -> reg_a=reg_b=0x07.
- Halt and enable: en=0 for 3 cycles -> no state change; halt instruction -> halted=1 next cycle, pc frozen, retired counter (if CPU_RETIRE_CNT_EN) stops.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU core: opcode field positions,
// ALU select and jump encodings, flag bit positions and the run/halt states.
package cpu_pkg;

  localparam int OP_W       = 9;
  localparam int OP_ALU_LSB = 0;
  localparam int OP_LD_A    = 3;
  localparam int OP_LD_B    = 4;
  localparam int OP_B_SRC   = 5;
  localparam int OP_JMP_LSB = 6;
  localparam int OP_HALT    = 8;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_NOT = 3'd7
  } alu_sel_e;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'd0,
    JMP_ALWAYS = 2'd1,
    JMP_Z      = 2'd2,
    JMP_NZ     = 2'd3
  } jmp_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core: eight operations with N/Z/C status outputs.
module alu_n
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_e          sel,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] ext;

  // ext[DATA_W] carries C; subtraction is A + ~B + 1 so C means "no borrow"
  always_comb begin
    ext = '0;
    case (sel)
      ALU_ADD: ext = {1'b0, a} + {1'b0, b};
      ALU_SUB: ext = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      ALU_AND: ext = {1'b0, a & b};
      ALU_OR:  ext = {1'b0, a | b};
      ALU_XOR: ext = {1'b0, a ^ b};
      ALU_SHL: ext = {a, 1'b0};
      ALU_SHR: ext = {a[0], 1'b0, a[DATA_W-1:1]};
      ALU_NOT: ext = {1'b0, ~a};
      default: ext = '0;
    endcase
    result = ext[DATA_W-1:0];
    c      = ext[DATA_W];
  end

  assign n = result[DATA_W-1];
  assign z = (result == '0);

endmodule

// File: rtl/cpu_core.sv
// Single-cycle accumulator CPU core with A/B registers, flags, jumps and HALT.
// Optional CPU_RETIRE_CNT_EN adds a 32-bit retired-instruction counter port.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [ADDR_W-1:0]      im_addr,
  input  logic [OP_W+DATA_W-1:0] im_data,
  output logic [ADDR_W-1:0]      pc,
  output logic [DATA_W-1:0]      reg_a,
  output logic [DATA_W-1:0]      reg_b,
  output logic [DATA_W-1:0]      alu_out,
  output logic [2:0]             flags,
  output logic                   halted
`ifdef CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]            retired
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        flags_q, flags_d;
`ifdef CPU_RETIRE_CNT_EN
  logic [31:0]       retired_q, retired_d;
`endif

  logic [DATA_W-1:0] k, b_op, alu_res;
  logic [OP_W-1:0]   op;
  alu_sel_e          alu_sel;
  jmp_e              jmp;
  logic              alu_n_f, alu_z_f, alu_c_f, taken;

  assign k       = im_data[DATA_W-1:0];
  assign op      = im_data[OP_W+DATA_W-1:DATA_W];
  assign alu_sel = alu_sel_e'(op[OP_ALU_LSB +: 3]);
  assign jmp     = jmp_e'(op[OP_JMP_LSB +: 2]);
  assign b_op    = op[OP_B_SRC] ? k : b_q;

  alu_n #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_op),
    .sel    (alu_sel),
    .result (alu_res),
    .n      (alu_n_f),
    .z      (alu_z_f),
    .c      (alu_c_f)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
`ifdef CPU_RETIRE_CNT_EN
    retired_d = retired_q;
`endif
    case (jmp)
      JMP_ALWAYS: taken = 1'b1;
      JMP_Z:      taken = flags_q[FLAG_Z];
      JMP_NZ:     taken = ~flags_q[FLAG_Z];
      default:    taken = 1'b0;
    endcase
    if (en && (state_q == ST_RUN)) begin
`ifdef CPU_RETIRE_CNT_EN
      retired_d = retired_q + 32'd1;
`endif
      if (op[OP_HALT]) begin
        state_d = ST_HALT;
      end else if (jmp != JMP_NONE) begin
        pc_d = taken ? k[ADDR_W-1:0] : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        if (op[OP_LD_A]) a_d = alu_res;
        if (op[OP_LD_B]) b_d = alu_res;
        flags_d = {alu_n_f, alu_z_f, alu_c_f};
        pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
`ifdef CPU_RETIRE_CNT_EN
      retired_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
`ifdef CPU_RETIRE_CNT_EN
      retired_q <= retired_d;
`endif
    end
  end

  assign im_addr = pc_q;
  assign pc      = pc_q;
  assign reg_a   = a_q;
  assign reg_b   = b_q;
  assign alu_out = alu_res;
  assign flags   = flags_q;
  assign halted  = (state_q == ST_HALT);
`ifdef CPU_RETIRE_CNT_EN
  assign retired = retired_q;
`endif

endmodule
